cfu_cmd_initiator: RTL and testbench
====================================

// Module: cfu_cmd_initiator
// PURPOSE
//  CPU-side initiator for the CFU command/response interface. Accepts one request
//  (function_id, two 32-bit operands) on a valid/ready port, drives the cmd_* channel
//  to a CFU, collects rsp_* and returns the result with latency/status. One
//  transaction outstanding. Used by the op-sequencer and as the bench driver for CFUs.
// PARAMETERS
//  FUNC_W      10   width of function_id (funct7 in [9:3], funct3 in [2:0])
//  DATA_W      32   operand/result width
//  LAT_W       16   width of latency and transaction counters (saturating)
//  TIMEOUT     256  cycles waited for rsp_valid before abort (only with CFU_INIT_TIMEOUT_EN)
// PORTS
//  clk                     in   1       clock
//  reset_n                 in   1       async active-low reset
//  req_valid               in   1       request present
//  req_ready               out  1       request accepted when valid&ready
//  req_function_id         in   FUNC_W  function id to issue
//  req_inputs_0/1          in   DATA_W  operands
//  res_valid               out  1       result held until res_ready
//  res_ready               in   1       consumer takes result
//  res_data                out  DATA_W  CFU rsp_payload_outputs_0 (0 on error)
//  res_err                 out  1       1 = timed out (only with CFU_INIT_TIMEOUT_EN, else tied 0)
//  res_latency             out  LAT_W   cycles from cmd accept to rsp accept, saturating
//  txn_count               out  LAT_W   completed transactions since reset, saturating
//  cmd_valid               out  1       to CFU
//  cmd_ready               in   1       from CFU
//  cmd_payload_function_id out  FUNC_W  registered copy of req_function_id
//  cmd_payload_inputs_0/1  out  DATA_W  registered operands
//  rsp_valid               in   1       from CFU
//  rsp_ready               out  1       to CFU
//  rsp_payload_outputs_0   in   DATA_W  CFU result
// BEHAVIOUR
//  - Reset (async, any state): FSM=IDLE; all outputs 0; counters 0; payload regs 0.
//  - FSM IDLE: req_ready=1. On req_valid: latch id/operands, -> CMD next cycle.
//  - CMD: cmd_valid=1, payload stable. On cmd_ready: lat=0, -> RSP. cmd_valid never
//    drops before cmd_ready; payload never changes while cmd_valid=1.
//  - RSP: rsp_ready=1, lat increments each cycle (saturates at all-ones). On rsp_valid:
//    latch res_data=rsp_payload_outputs_0, res_latency=lat, res_err=0, txn_count++
//    (saturating), -> DONE. Same-cycle CMD accept then RSP: min latency 1 cycle (1 = first RSP cycle).
//  - DONE: res_valid=1, outputs stable. On res_ready -> IDLE. req_ready=0 here; no
//    request/result overlap, so min request-to-request period is 4 cycles.
//  - rsp_ready is 0 in IDLE/CMD/DONE; rsp_valid seen there is ignored (protocol error).
//  - req_ready, cmd_valid, rsp_ready, res_valid are decoded purely from FSM state (registered).
// CONFIGURATION
//  CFU_INIT_TIMEOUT_EN defined: in RSP, lat reaching TIMEOUT -> DRAIN with res_err=1,
//    res_data=0, res_latency=TIMEOUT, txn_count unchanged; res_valid=1 in DRAIN.
//    DRAIN keeps rsp_ready=1 and discards first rsp_valid; -> IDLE when both late
//    response drained and res_ready seen (either order). Never-responding CFU: stays DRAIN.
//  Undefined: no DRAIN state, no timeout; RSP waits indefinitely; res_err tied 0.
// STRUCTURE
//  Package cfu_if_pkg: FUNC_W/DATA_W constants, state enum
//    {IDLE,CMD,RSP,DONE,DRAIN}, cfu_req_t struct {function_id, inputs_0, inputs_1}.
//  Sub-module cfu_sat_counter (width param, clear/inc, saturating) for lat and txn_count.
// TESTING  (CFU model = SIMD MAC: funct7=1 sets offset; funct7=0 accumulates)
//  1 reset_n low mid-RSP -> next cycle all outputs 0, FSM IDLE, req_ready=1 after release.
//  2 id=0x008,in0=128 then id=0x000,in0=0x01010101,in1=0x02020202, rsp delay 0 ->
//    res_data 0 then 0x00000408, res_latency=1, txn_count=2.
//  3 CFU holds cmd_ready=0 5 cycles -> cmd_valid and payload stable all 5, one accept only.
//  4 res_ready held 0 10 cycles -> res_valid/res_data stable, req_ready=0, no 2nd cmd.
//  5 rsp delay 300 with TIMEOUT=256, macro defined -> res_err=1,res_data=0,res_latency=256,
//    late rsp consumed in DRAIN, next txn correct; macro undefined -> success, latency 300.
//  6 back-to-back 70000 txns, LAT_W=16 -> txn_count saturates at 0xFFFF, no wrap.

Source files
------------

// File: rtl/cfu_if_pkg.sv
// Shared types and widths for the CPU-to-CFU command/response interface.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cfu_if_pkg;

    localparam int FUNC_W = 10;
    localparam int DATA_W = 32;

    // DRAIN is only entered when the response timeout is compiled in.
    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RSP,
        DONE,
        DRAIN
    } state_t;

    // One CFU request as carried on the cmd_* channel.
    typedef struct packed {
        logic [FUNC_W-1:0] function_id;
        logic [DATA_W-1:0] inputs_0;
        logic [DATA_W-1:0] inputs_1;
    } cfu_req_t;

endpackage

// File: rtl/cfu_sat_counter.sv
// Saturating up-counter with a synchronous clear that loads INIT.
// Latency: count reflects clear/inc one cycle after they are sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
module cfu_sat_counter #(
    parameter int           W    = 16,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear wins over increment; increment stops at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= INIT;
        end else if (inc && !(&count)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/cfu_cmd_initiator.sv
// CPU-side initiator: takes one request, drives cmd_* to a CFU, returns rsp with latency.
// Latency: req accept -> cmd_valid 1 cycle; rsp accept -> res_valid 1 cycle; one txn in flight.
// Backpressure: req_ready low from accept until res_ready; CFU_INIT_TIMEOUT_EN adds rsp timeout.
module cfu_cmd_initiator #(
    parameter int FUNC_W = cfu_if_pkg::FUNC_W,
    parameter int DATA_W = cfu_if_pkg::DATA_W,
    parameter int LAT_W  = 16
`ifdef CFU_INIT_TIMEOUT_EN
    , parameter int TIMEOUT = 256
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [FUNC_W-1:0] req_function_id,
    input  logic [DATA_W-1:0] req_inputs_0,
    input  logic [DATA_W-1:0] req_inputs_1,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
    output logic [LAT_W-1:0]  res_latency,
    output logic [LAT_W-1:0]  txn_count,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [FUNC_W-1:0] cmd_payload_function_id,
    output logic [DATA_W-1:0] cmd_payload_inputs_0,
    output logic [DATA_W-1:0] cmd_payload_inputs_1,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [DATA_W-1:0] rsp_payload_outputs_0
);

    import cfu_if_pkg::*;

    state_t           state;
    logic [LAT_W-1:0] lat;
    logic             lat_clear;
    logic             lat_inc;
    logic             txn_inc;

    // lat is loaded with 1 on cmd accept so that its value in any RSP cycle is
    // already that cycle's latency (first RSP cycle reports 1).
    assign lat_clear = (state == CMD) && cmd_ready;
    assign lat_inc   = (state == RSP);
    assign txn_inc   = (state == RSP) && rsp_valid;

    cfu_sat_counter #(.W(LAT_W), .INIT(LAT_W'(1))) u_lat_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (lat_clear),
        .inc     (lat_inc),
        .count   (lat)
    );

    cfu_sat_counter #(.W(LAT_W), .INIT('0)) u_txn_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (1'b0),
        .inc     (txn_inc),
        .count   (txn_count)
    );

`ifdef CFU_INIT_TIMEOUT_EN
    localparam logic [LAT_W-1:0] TIMEOUT_LAT = LAT_W'(TIMEOUT);

    logic res_err_q;
    logic rsp_drained;
    logic res_taken;
    logic rsp_done;
    logic res_done;

    // In DRAIN the late response and the error result retire independently.
    assign rsp_done = rsp_drained | (rsp_valid & rsp_ready);
    assign res_done = res_taken | (res_valid & res_ready);
    assign res_err  = res_err_q;
`else
    assign res_err  = 1'b0;
`endif

    // Transaction FSM; all handshake outputs are registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= IDLE;
            req_ready               <= 1'b0;
            cmd_valid               <= 1'b0;
            rsp_ready               <= 1'b0;
            res_valid               <= 1'b0;
            res_data                <= '0;
            res_latency             <= '0;
            cmd_payload_function_id <= '0;
            cmd_payload_inputs_0    <= '0;
            cmd_payload_inputs_1    <= '0;
`ifdef CFU_INIT_TIMEOUT_EN
            res_err_q               <= 1'b0;
            rsp_drained             <= 1'b0;
            res_taken               <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        cmd_payload_function_id <= req_function_id;
                        cmd_payload_inputs_0    <= req_inputs_0;
                        cmd_payload_inputs_1    <= req_inputs_1;
                        req_ready               <= 1'b0;
                        cmd_valid               <= 1'b1;
                        state                   <= CMD;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                CMD: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        rsp_ready <= 1'b1;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_valid) begin
                        res_data    <= rsp_payload_outputs_0;
                        res_latency <= lat;
                        rsp_ready   <= 1'b0;
                        res_valid   <= 1'b1;
                        state       <= DONE;
`ifdef CFU_INIT_TIMEOUT_EN
                        res_err_q   <= 1'b0;
                    end else if (lat == TIMEOUT_LAT) begin
                        // Keep rsp_ready high so a late response is swallowed.
                        res_data    <= '0;
                        res_latency <= TIMEOUT_LAT;
                        res_err_q   <= 1'b1;
                        res_valid   <= 1'b1;
                        rsp_drained <= 1'b0;
                        res_taken   <= 1'b0;
                        state       <= DRAIN;
`endif
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
`ifdef CFU_INIT_TIMEOUT_EN
                DRAIN: begin
                    if (rsp_done && res_done) begin
                        rsp_ready   <= 1'b0;
                        res_valid   <= 1'b0;
                        rsp_drained <= 1'b0;
                        res_taken   <= 1'b0;
                        req_ready   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        rsp_ready   <= !rsp_done;
                        res_valid   <= !res_done;
                        rsp_drained <= rsp_done;
                        res_taken   <= res_done;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfu_cmd_initiator.sv
// Bench for cfu_cmd_initiator against a SIMD-MAC CFU model with a result scoreboard.
// Latency: n/a.
// Backpressure: exercises cmd_ready stalls, slow responses and res_ready holds.
module tb_cfu_cmd_initiator;

    localparam int FUNC_W = 10;
    localparam int DATA_W = 32;
    localparam int LAT_W  = 9;   // small enough to reach txn_count saturation quickly

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid;
    logic              req_ready;
    logic [FUNC_W-1:0] req_function_id;
    logic [DATA_W-1:0] req_inputs_0;
    logic [DATA_W-1:0] req_inputs_1;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_err;
    logic [LAT_W-1:0]  res_latency;
    logic [LAT_W-1:0]  txn_count;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [FUNC_W-1:0] cmd_payload_function_id;
    logic [DATA_W-1:0] cmd_payload_inputs_0;
    logic [DATA_W-1:0] cmd_payload_inputs_1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_payload_outputs_0;

    cfu_cmd_initiator #(.FUNC_W(FUNC_W), .DATA_W(DATA_W), .LAT_W(LAT_W)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_function_id         (req_function_id),
        .req_inputs_0            (req_inputs_0),
        .req_inputs_1            (req_inputs_1),
        .res_valid               (res_valid),
        .res_ready               (res_ready),
        .res_data                (res_data),
        .res_err                 (res_err),
        .res_latency             (res_latency),
        .txn_count               (txn_count),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [31:0] lat;
    } exp_t;

    exp_t exp_q[$];

    // ---------------- CFU model (SIMD MAC) ----------------
    int          cmd_stall = 0;   // cycles cmd_ready is withheld per command
    int          rsp_delay = 0;   // response appears in RSP cycle rsp_delay+1
    int          phase = 0;
    bit          seen = 0;
    bit          hs = 0;
    int          stall_left = 0;
    int          wait_left = 0;
    int          cmd_acc = 0;
    int          stall_obs = 0;
    logic [9:0]  cap_id;
    logic [31:0] cap_in0, cap_in1;
    logic [31:0] offset, acc, result, sum;

    initial begin : cfu_model
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_payload_outputs_0 = '0;
        offset = '0;
        acc = '0;
        result = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                phase = 0; seen = 0; hs = 0;
                cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_payload_outputs_0 = '0;
                offset = '0; acc = '0;
            end else begin
                case (phase)
                    0: begin
                        cmd_ready = 1'b0;
                        if (seen) begin
                            chk("cmd_valid_held", {31'd0, cmd_valid}, 32'd1);
                            chk("cmd_id_stable", {22'd0, cmd_payload_function_id}, {22'd0, cap_id});
                            chk("cmd_in0_stable", cmd_payload_inputs_0, cap_in0);
                            chk("cmd_in1_stable", cmd_payload_inputs_1, cap_in1);
                        end
                        if (cmd_valid) begin
                            if (!seen) begin
                                seen = 1; stall_left = cmd_stall;
                                cap_id = cmd_payload_function_id;
                                cap_in0 = cmd_payload_inputs_0;
                                cap_in1 = cmd_payload_inputs_1;
                            end
                            if (stall_left > 0) begin
                                stall_left--;
                                stall_obs++;
                            end else begin
                                cmd_ready = 1'b1;
                                seen = 0;
                                cmd_acc++;
                                if (cap_id[9:3] == 7'd1) begin
                                    offset = cap_in0;
                                    result = '0;
                                end else if (cap_id[9:3] == 7'd0) begin
                                    sum = '0;
                                    for (int b = 0; b < 4; b++)
                                        sum = sum + (cap_in0[8*b +: 8] + offset) * cap_in1[8*b +: 8];
                                    acc = acc + sum;
                                    result = acc;
                                end else begin
                                    result = 32'hDEAD_BEEF;
                                end
                                wait_left = rsp_delay;
                                phase = 1;
                            end
                        end
                    end
                    1: begin
                        cmd_ready = 1'b0;
                        if (wait_left > 0) begin
                            wait_left--;
                        end else begin
                            rsp_valid = 1'b1;
                            rsp_payload_outputs_0 = result;
                            hs = rsp_ready;
                            phase = 2;
                        end
                    end
                    default: begin
                        if (hs) begin
                            rsp_valid = 1'b0;
                            rsp_payload_outputs_0 = '0;
                            phase = 0;
                        end else begin
                            hs = rsp_ready;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- result consumer ----------------
    int res_hold = 0;

    initial begin : res_driver
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (res_valid && res_hold > 0) begin
                res_ready = 1'b0;
                res_hold--;
            end else begin
                res_ready = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    int          hold_obs = 0;
    bit          held = 0;
    logic [31:0] prev_data, prev_lat;
    logic        prev_err;
    logic [31:0] exp_txn = 0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_txn = 0;
                held = 0;
            end else if (res_valid) begin
                if (!res_ready) begin
                    hold_obs++;
                    chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
                    chk("hold_cmd_valid", {31'd0, cmd_valid}, 32'd0);
                    if (held) begin
                        chk("hold_res_data", res_data, prev_data);
                        chk("hold_res_latency", {23'd0, res_latency}, prev_lat);
                        chk("hold_res_err", {31'd0, res_err}, {31'd0, prev_err});
                    end
                    held = 1;
                    prev_data = res_data;
                    prev_lat = {23'd0, res_latency};
                    prev_err = res_err;
                end else begin
                    held = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL res_unexpected: result 0x%08h with no expectation queued", res_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_data", res_data, e.data);
                        chk("res_err", {31'd0, res_err}, {31'd0, e.err});
                        chk("res_latency", {23'd0, res_latency}, e.lat);
                        if (!e.err && exp_txn != 32'h1FF) exp_txn = exp_txn + 1;
                        chk("txn_count", {23'd0, txn_count}, exp_txn);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_req(input logic [9:0] id, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] d, input logic err, input logic [31:0] lat);
        exp_t e;
        bit   ok = 0;
        e.data = d; e.err = err; e.lat = lat;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_function_id = id; req_inputs_0 = a; req_inputs_1 = b; req_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("req_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_quiet();
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !res_valid) begin
                ok = 1;
                break;
            end
        end
        chk("results_drained", {31'd0, ok}, 32'd1);
    endtask

    task automatic check_zero(input string p);
        chk({p, "_req_ready"}, {31'd0, req_ready}, 32'd0);
        chk({p, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
        chk({p, "_rsp_ready"}, {31'd0, rsp_ready}, 32'd0);
        chk({p, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        chk({p, "_res_data"}, res_data, 32'd0);
        chk({p, "_res_err"}, {31'd0, res_err}, 32'd0);
        chk({p, "_res_latency"}, {23'd0, res_latency}, 32'd0);
        chk({p, "_txn_count"}, {23'd0, txn_count}, 32'd0);
        chk({p, "_cmd_id"}, {22'd0, cmd_payload_function_id}, 32'd0);
        chk({p, "_cmd_in0"}, cmd_payload_inputs_0, 32'd0);
        chk({p, "_cmd_in1"}, cmd_payload_inputs_1, 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 60000 cycles");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    int acc_b, stall_b, hold_b;

    initial begin : main
        req_valid = 1'b0;
        req_function_id = '0;
        req_inputs_0 = '0;
        req_inputs_1 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("rst");
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rel_req_ready", {31'd0, req_ready}, 32'd1);

        // Reset asserted while waiting for a response
        rsp_delay = 40;
        send_req(10'h008, 32'h55, 32'h0, 32'h0, 1'b0, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rsp_ready", {31'd0, rsp_ready}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rel2_req_ready", {31'd0, req_ready}, 32'd1);

        // Set offset 128, then MAC: 4 * (1+128)*2 = 0x408
        rsp_delay = 0;
        send_req(10'h008, 32'd128, 32'h0, 32'h0, 1'b0, 32'd1);
        send_req(10'h000, 32'h0101_0101, 32'h0202_0202, 32'h0000_0408, 1'b0, 32'd1);
        wait_quiet();
        chk("t2_txn_count", {23'd0, txn_count}, 32'd2);

        // cmd_ready withheld 5 cycles; acc = 0x408 + 4*129 = 0x60C, response in RSP cycle 3
        cmd_stall = 5;
        rsp_delay = 2;
        acc_b = cmd_acc;
        stall_b = stall_obs;
        send_req(10'h000, 32'h0101_0101, 32'h0101_0101, 32'h0000_060C, 1'b0, 32'd3);
        wait_quiet();
        chk("t3_stall_cycles", stall_obs - stall_b, 32'd5);
        chk("t3_cmd_accepts", cmd_acc - acc_b, 32'd1);
        cmd_stall = 0;

        // Result held for 10 cycles while a second request waits; offset 0, acc += 3*5
        rsp_delay = 0;
        hold_b = hold_obs;
        acc_b = cmd_acc;
        res_hold = 10;
        send_req(10'h008, 32'h0, 32'h0, 32'h0, 1'b0, 32'd1);
        send_req(10'h000, 32'h3, 32'h5, 32'h0000_061B, 1'b0, 32'd1);
        wait_quiet();
        chk("t4_hold_cycles", hold_obs - hold_b, 32'd10);
        chk("t4_cmd_accepts", cmd_acc - acc_b, 32'd2);

        // Response arrives in the 300th RSP cycle
        rsp_delay = 299;
`ifdef CFU_INIT_TIMEOUT_EN
        send_req(10'h008, 32'd7, 32'h0, 32'h0, 1'b1, 32'd256);
`else
        send_req(10'h008, 32'd7, 32'h0, 32'h0, 1'b0, 32'd300);
`endif
        wait_quiet();
        rsp_delay = 0;
        // offset 7: (1+7)*2 = 16 -> acc 0x62B
        send_req(10'h000, 32'h1, 32'h2, 32'h0000_062B, 1'b0, 32'd1);
        wait_quiet();

        // txn_count saturation (LAT_W=9 -> 0x1FF)
        for (int n = 0; n < 520; n++)
            send_req(10'h008, 32'h0, 32'h0, 32'h0, 1'b0, 32'd1);
        wait_quiet();
        chk("t6_txn_sat", {23'd0, txn_count}, 32'h1FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
